pifo_task_scheduler: RTL and testbench
======================================

Name: pifo_task_scheduler

Overview:
- Multi-tree task front end that sits between the traffic generator and the per-tree BMW PIFO instances.
- Accepts pushes tagged with a tree id into per-tree FIFOs.
- On each pop request, selects one non-empty, enabled tree by round-robin or strict priority and returns its head task with the tree id.
- Generalises the single shared task FIFO to per-tree queues, with per-tree full/empty status, a tree enable mask, a selectable arbitration mode and drop/underflow reporting.

Parameters:
- PTW, 16, priority field width.
- MTW, 0, metadata width; data word is MTW+PTW bits.
- TREE_NUM, 4, number of trees (>=2).
- DEPTH, 16, entries per tree FIFO; power of 2, >=2.
- MODE, 0, arbitration: 0 = round-robin, 1 = strict priority (lowest tree id wins).
- TREE_NUM_BITS, $clog2(TREE_NUM), tree id width (derived).

Ports:
- i_clk  in  1  clock; all state on rising edge.
- i_arst_n  in  1  asynchronous active-low reset.
- i_push  in  1  push request.
- i_push_tree_id  in  TREE_NUM_BITS  target tree of push.
- i_push_data  in  MTW+PTW  pushed task.
- i_pop  in  1  pop request.
- i_tree_en  in  TREE_NUM  per-tree pop enable mask.
- o_pop_valid  out  1  pop result valid (registered).
- o_pop_tree_id  out  TREE_NUM_BITS  tree of popped task.
- o_pop_data  out  MTW+PTW  popped task.
- o_tree_full  out  TREE_NUM  per-tree full flags.
- o_tree_empty  out  TREE_NUM  per-tree empty flags.
- o_push_drop  out  1  one-cycle pulse: previous push was discarded.
- o_pop_underflow  out  1  one-cycle pulse: previous pop found no eligible tree.

Behaviour:
- Reset (asynchronous assert, synchronous deassert at the edge):
  - all counters and read/write pointers clear; RR pointer = 0;
  - o_pop_valid, o_pop_tree_id, o_pop_data, o_push_drop, o_pop_underflow = 0;
  - o_tree_empty = all 1; o_tree_full = all 0;
  - FIFO storage is not reset.
- Per-tree state: write pointer, read pointer (log2 DEPTH bits, natural wrap) and count (log2 DEPTH + 1 bits).
  - full = (count == DEPTH); empty = (count == 0).
  - o_tree_full and o_tree_empty decode count combinationally.
- Push:
  - Accepted when i_push and the target tree is not full, judged on pre-edge count.
  - Accepted: data is written at wr_ptr, wr_ptr++, count++.
  - Push to a full tree is discarded and o_push_drop = 1 the next cycle, even if the same cycle pops that tree.
  - i_push_tree_id >= TREE_NUM is discarded with o_push_drop.
- Pop eligibility: tree t is eligible when it is non-empty (pre-edge) and i_tree_en[t] = 1. A task pushed in the same cycle is never eligible.
- Pop arbitration:
  - MODE 0: search starts at rr_ptr, increments mod TREE_NUM, and takes the first eligible tree k. On grant, rr_ptr <= k+1 mod TREE_NUM. rr_ptr is unchanged when there is no grant.
  - MODE 1: lowest eligible id wins; rr_ptr is unused.
- Pop latency is 1 cycle. On the edge after i_pop with a grant:
  - o_pop_valid = 1, o_pop_tree_id = k, o_pop_data = head of k;
  - rd_ptr[k]++, count[k]--.
- Pop with no eligible tree: o_pop_valid = 0, o_pop_underflow = 1 next cycle; the data and tree id outputs hold their previous values.
- Cycle without i_pop: o_pop_valid = 0 and the data outputs hold.
- Simultaneous push and pop on the same tree:
  - Both take effect when that tree is non-full and non-empty; count is unchanged.
  - Push into an empty tree concurrent with a pop: the pop is not granted to that tree.
- Back-to-back pops every cycle are supported; each cycle's grant sees the counts updated by the previous edge.
- Reset mid-operation: all queued tasks are lost and flags return to reset values immediately (asynchronously).

Decomposition:
- Package pifo_sched_pkg holds:
  - the task word typedef (MTW+PTW bits);
  - the tree id typedef;
  - MODE_RR = 0 and MODE_SP = 1 localparams;
  - a function rr_pick(eligible mask, start) returning the grant index and a found bit.
- One sub-module is natural: pifo_sched_tree_fifo.
  - One per tree via generate.
  - Holds the storage, pointers and count.
  - Exposes push/pop strobes, head data, full and empty.
  - The top level holds the arbiter, RR pointer and output registers.

Test Plan:
- Reset, then idle: o_tree_empty = 4'b1111, o_tree_full = 0, o_pop_valid = 0 and no pulses.
- MODE 0: for j = 1..4, for i = 1..3, push data 4096*i+j to tree i (12 pushes). Then 12 consecutive pops return 0x1001, 0x2001, 0x3001, 0x1002, 0x2002, …, 0x3004 with tree ids 1, 2, 3 repeating. Afterwards trees 1-3 are empty.
- Fill tree 2 with 16 pushes (0..15): o_tree_full[2] = 1. A 17th push sets o_push_drop for one cycle. 16 pops return 0..15 in order, exercising pointer wrap.
- With 2 tasks each in trees 0 and 3 and i_tree_en = 4'b0111: pops return tree 0, tree 0, then underflow. Set i_tree_en = 4'b1111: pops return tree 3 twice.
- MODE 1: with tasks in trees 1 and 2, interleave a push to tree 0 with pops. Tree 0 wins from the cycle after its push; tree 2 is served only after trees 0 and 1 are empty.
- Pop on all-empty: o_pop_underflow pulses with o_pop_valid = 0. Asserting i_arst_n = 0 mid-stream clears all flags and outputs within the same cycle.

Source files
------------

// File: rtl/pifo_sched_pkg.sv
// -----------------------------------------------------------------------------
// pifo_sched_pkg
// Shared types and helpers for the multi-tree PIFO task scheduler.
//   task_t     : task word at the default widths (metadata + priority)
//   tree_id_t  : tree index at the default tree count
//   MODE_RR    : round-robin arbitration
//   MODE_SP    : strict priority, lowest tree id wins
//   rr_pick()  : round-robin search over an eligibility mask
// -----------------------------------------------------------------------------
package pifo_sched_pkg;

   localparam int PTW_DEF      = 16;
   localparam int MTW_DEF      = 0;
   localparam int TREE_NUM_DEF = 4;

   localparam int MODE_RR = 0;
   localparam int MODE_SP = 1;

   // Upper bound on tree count handled by rr_pick's fixed-width mask.
   localparam int MAX_TREES = 32;
   localparam int MAX_IDX_W = $clog2(MAX_TREES);

   typedef logic [MTW_DEF+PTW_DEF-1:0]     task_t;
   typedef logic [$clog2(TREE_NUM_DEF)-1:0] tree_id_t;

   typedef struct packed {
      logic                 found;
      logic [MAX_IDX_W-1:0] idx;
   } pick_t;

   // First set bit of elig[n-1:0] found by walking upward from start with
   // wrap at n. start must be < n.
   function automatic pick_t rr_pick(input logic [MAX_TREES-1:0] elig,
                                     input int unsigned          start,
                                     input int unsigned          n);
      pick_t       r;
      int unsigned k;
      r = '0;
      for (int unsigned i = 0; i < MAX_TREES; i++) begin
         if (i < n) begin
            k = start + i;
            if (k >= n) k = k - n;
            if (!r.found && elig[k]) begin
               r.found = 1'b1;
               r.idx   = MAX_IDX_W'(k);
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/pifo_sched_tree_fifo.sv
// -----------------------------------------------------------------------------
// pifo_sched_tree_fifo
// Single-tree task FIFO. The parent only strobes push when not full and pop
// when not empty, so the strobes are taken as already qualified.
//   i_clk, i_arst_n : clock, asynchronous active-low reset
//   i_push          : write i_push_data at the tail
//   i_push_data     : task word
//   i_pop           : retire the head entry
//   o_head          : current head entry (valid when !o_empty)
//   o_full, o_empty : decoded from the occupancy count
// -----------------------------------------------------------------------------
module pifo_sched_tree_fifo #(
   parameter int W     = 16,
   parameter int DEPTH = 16
) (
   input  logic         i_clk,
   input  logic         i_arst_n,
   input  logic         i_push,
   input  logic [W-1:0] i_push_data,
   input  logic         i_pop,
   output logic [W-1:0] o_head,
   output logic         o_full,
   output logic         o_empty
);

   localparam int             AW       = $clog2(DEPTH);
   localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;

   // NOTE: storage carries no reset; the count alone defines which entries
   // are live, so resetting the array would only cost flops and routing.
   always_ff @(posedge i_clk) begin
      if (i_push) mem[wr_ptr] <= i_push_data;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of process evaluation order.
   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (i_push) wr_ptr <= wr_ptr + 1'b1;
         if (i_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({i_push, i_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign o_head  = mem[rd_ptr];
   assign o_full  = (count == FULL_CNT);
   assign o_empty = (count == '0);

endmodule

// File: rtl/pifo_task_scheduler.sv
// -----------------------------------------------------------------------------
// pifo_task_scheduler
// Per-tree task queues in front of the BMW PIFO trees. Pushes are steered to
// the tree named by i_push_tree_id; each pop picks one non-empty, enabled tree
// (round-robin or strict priority) and returns its head one cycle later.
//   i_clk, i_arst_n  : clock, asynchronous active-low reset
//   i_push           : push request, target i_push_tree_id, word i_push_data
//   i_pop            : pop request
//   i_tree_en        : per-tree pop enable mask
//   o_pop_valid      : registered pop result strobe
//   o_pop_tree_id    : tree of popped task (holds when no grant)
//   o_pop_data       : popped task (holds when no grant)
//   o_tree_full      : per-tree full flags
//   o_tree_empty     : per-tree empty flags
//   o_push_drop      : pulse, previous push was discarded
//   o_pop_underflow  : pulse, previous pop found no eligible tree
// -----------------------------------------------------------------------------
module pifo_task_scheduler
   import pifo_sched_pkg::*;
#(
   parameter int PTW           = PTW_DEF,
   parameter int MTW           = MTW_DEF,
   parameter int TREE_NUM      = TREE_NUM_DEF,
   parameter int DEPTH         = 16,
   parameter int MODE          = MODE_RR,
   parameter int TREE_NUM_BITS = $clog2(TREE_NUM)
) (
   input  logic                     i_clk,
   input  logic                     i_arst_n,
   input  logic                     i_push,
   input  logic [TREE_NUM_BITS-1:0] i_push_tree_id,
   input  logic [MTW+PTW-1:0]       i_push_data,
   input  logic                     i_pop,
   input  logic [TREE_NUM-1:0]      i_tree_en,
   output logic                     o_pop_valid,
   output logic [TREE_NUM_BITS-1:0] o_pop_tree_id,
   output logic [MTW+PTW-1:0]       o_pop_data,
   output logic [TREE_NUM-1:0]      o_tree_full,
   output logic [TREE_NUM-1:0]      o_tree_empty,
   output logic                     o_push_drop,
   output logic                     o_pop_underflow
);

   localparam int            DW      = MTW + PTW;
   localparam int            TW      = TREE_NUM_BITS;
   localparam logic [TW-1:0] LAST_ID = TW'(TREE_NUM - 1);

   logic [TREE_NUM-1:0]  push_sel;
   logic [TREE_NUM-1:0]  pop_sel;
   logic [TREE_NUM-1:0]  elig;
   logic [MAX_TREES-1:0] elig_wide;
   logic [DW-1:0]        heads [TREE_NUM];
   logic                 push_accept;
   logic                 grant;
   logic [TW-1:0]        grant_id;
   logic [TW-1:0]        rr_ptr;
   pick_t                pick;

   // A tree id outside 0..TREE_NUM-1 matches no select line and is dropped.
   // Eligibility uses the pre-edge empty flag, so a task pushed this cycle
   // can never be popped in the same cycle.
   for (genvar t = 0; t < TREE_NUM; t++) begin : g_tree
      assign push_sel[t] = i_push && (i_push_tree_id == TW'(t)) && !o_tree_full[t];
      assign pop_sel[t]  = grant && (grant_id == TW'(t));
      assign elig[t]     = !o_tree_empty[t] && i_tree_en[t];

      pifo_sched_tree_fifo #(
         .W     (DW),
         .DEPTH (DEPTH)
      ) u_fifo (
         .i_clk       (i_clk),
         .i_arst_n    (i_arst_n),
         .i_push      (push_sel[t]),
         .i_push_data (i_push_data),
         .i_pop       (pop_sel[t]),
         .o_head      (heads[t]),
         .o_full      (o_tree_full[t]),
         .o_empty     (o_tree_empty[t])
      );
   end

   assign push_accept = |push_sel;

   // NOTE: every variable driven here gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      elig_wide                = '0;
      elig_wide[TREE_NUM-1:0]  = elig;
      pick                     = '0;
      if (MODE == MODE_SP) begin
         // Descending walk: the last hit, i.e. the lowest id, wins.
         for (int t = TREE_NUM - 1; t >= 0; t--) begin
            if (elig[t]) begin
               pick.found = 1'b1;
               pick.idx   = MAX_IDX_W'(t);
            end
         end
      end else begin
         pick = rr_pick(elig_wide, 32'(rr_ptr), TREE_NUM);
      end
   end

   assign grant    = i_pop && pick.found;
   assign grant_id = TW'(pick.idx);

   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         rr_ptr          <= '0;
         o_pop_valid     <= 1'b0;
         o_pop_tree_id   <= '0;
         o_pop_data      <= '0;
         o_push_drop     <= 1'b0;
         o_pop_underflow <= 1'b0;
      end else begin
         o_push_drop     <= i_push && !push_accept;
         o_pop_underflow <= i_pop && !pick.found;
         o_pop_valid     <= grant;
         if (grant) begin
            o_pop_tree_id <= grant_id;
            o_pop_data    <= heads[grant_id];
            if (MODE == MODE_RR)
               rr_ptr <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pifo_task_scheduler.sv
// -----------------------------------------------------------------------------
// tb_pifo_task_scheduler
// Drives one round-robin and one strict-priority instance with the same
// stimulus. A queue-based reference model tracks each instance and is compared
// every cycle; directed sequences add explicit expected values.
// -----------------------------------------------------------------------------
module tb_pifo_task_scheduler;
   import pifo_sched_pkg::*;

   typedef task_t word_t;

   logic        clk;
   logic        rst_n;
   logic        push;
   tree_id_t    push_id;
   word_t       push_data;
   logic        pop;
   logic [3:0]  tree_en;

   logic        pop_valid [2];
   tree_id_t    pop_id    [2];
   word_t       pop_data  [2];
   logic [3:0]  full      [2];
   logic [3:0]  empty     [2];
   logic        drop      [2];
   logic        uf        [2];

   int checks = 0;
   int errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   pifo_task_scheduler #(.MODE(MODE_RR)) dut_rr (
      .i_clk(clk), .i_arst_n(rst_n),
      .i_push(push), .i_push_tree_id(push_id), .i_push_data(push_data),
      .i_pop(pop), .i_tree_en(tree_en),
      .o_pop_valid(pop_valid[0]), .o_pop_tree_id(pop_id[0]), .o_pop_data(pop_data[0]),
      .o_tree_full(full[0]), .o_tree_empty(empty[0]),
      .o_push_drop(drop[0]), .o_pop_underflow(uf[0])
   );

   pifo_task_scheduler #(.MODE(MODE_SP)) dut_sp (
      .i_clk(clk), .i_arst_n(rst_n),
      .i_push(push), .i_push_tree_id(push_id), .i_push_data(push_data),
      .i_pop(pop), .i_tree_en(tree_en),
      .o_pop_valid(pop_valid[1]), .o_pop_tree_id(pop_id[1]), .o_pop_data(pop_data[1]),
      .o_tree_full(full[1]), .o_tree_empty(empty[1]),
      .o_push_drop(drop[1]), .o_pop_underflow(uf[1])
   );

   // ---------------- reference model (index 0 = RR, 1 = SP) ----------------
   word_t      mq [2][4][$];
   logic       m_valid [2];
   tree_id_t   m_id    [2];
   word_t      m_data  [2];
   logic       m_drop  [2];
   logic       m_uf    [2];
   int         m_rr    [2];

   task automatic model_step(input int m);
      bit found;
      bit was_full;
      int k;
      int t;
      was_full = (mq[m][push_id].size() == 16);
      found = 0;
      k = 0;
      for (int i = 0; i < 4; i++) begin
         t = (m == 0) ? (m_rr[m] + i) % 4 : i;
         if (!found && tree_en[t] && mq[m][t].size() > 0) begin
            found = 1;
            k = t;
         end
      end
      m_drop[m]  = push && was_full;
      m_uf[m]    = pop && !found;
      m_valid[m] = pop && found;
      if (pop && found) begin
         m_id[m]   = tree_id_t'(k);
         m_data[m] = mq[m][k].pop_front();
         if (m == 0) m_rr[m] = (k + 1) % 4;
      end
      if (push && !was_full) mq[m][push_id].push_back(push_data);
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int m = 0; m < 2; m++) begin
            for (int t = 0; t < 4; t++) mq[m][t].delete();
            m_valid[m] = 0; m_id[m] = 0; m_data[m] = 0;
            m_drop[m] = 0;  m_uf[m] = 0; m_rr[m] = 0;
         end
      end else begin
         for (int m = 0; m < 2; m++) model_step(m);
      end
   end

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_model();
      logic [3:0] ef;
      logic [3:0] ee;
      for (int m = 0; m < 2; m++) begin
         for (int t = 0; t < 4; t++) begin
            ef[t] = (mq[m][t].size() == 16);
            ee[t] = (mq[m][t].size() == 0);
         end
         check($sformatf("m%0d_valid", m), 32'(pop_valid[m]), 32'(m_valid[m]));
         check($sformatf("m%0d_id", m),    32'(pop_id[m]),    32'(m_id[m]));
         check($sformatf("m%0d_data", m),  32'(pop_data[m]),  32'(m_data[m]));
         check($sformatf("m%0d_drop", m),  32'(drop[m]),      32'(m_drop[m]));
         check($sformatf("m%0d_uf", m),    32'(uf[m]),        32'(m_uf[m]));
         check($sformatf("m%0d_full", m),  32'(full[m]),      32'(ef));
         check($sformatf("m%0d_empty", m), 32'(empty[m]),     32'(ee));
      end
   endtask

   // Called at a falling edge: drive, let one rising edge pass, check at the
   // next falling edge.
   task automatic step(input bit p, input tree_id_t id, input word_t d,
                       input bit po, input logic [3:0] en);
      push = p; push_id = id; push_data = d; pop = po; tree_en = en;
      @(negedge clk);
      check_model();
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 4'hF);
   endtask

   task automatic expect_pop(input int m, input string name, input tree_id_t id, input word_t d);
      check({name, "_valid"}, 32'(pop_valid[m]), 32'd1);
      check({name, "_id"},    32'(pop_id[m]),    32'(id));
      check({name, "_data"},  32'(pop_data[m]),  32'(d));
   endtask

   typedef struct {
      bit       push;
      tree_id_t id;
      word_t    data;
      bit       pop;
      logic [3:0] en;
      bit       exp_valid;
      tree_id_t exp_id;
      word_t    exp_data;
   } vec_t;

   vec_t tbl [$];

   initial begin
      vec_t v;
      rst_n = 1'b0;
      push = 0; push_id = 0; push_data = 0; pop = 0; tree_en = 4'hF;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Reset state
      for (int m = 0; m < 2; m++) begin
         check("rst_empty", 32'(empty[m]), 32'hF);
         check("rst_full",  32'(full[m]),  32'h0);
         check("rst_valid", 32'(pop_valid[m]), 32'h0);
         check("rst_drop",  32'(drop[m]), 32'h0);
         check("rst_uf",    32'(uf[m]), 32'h0);
      end
      idle(); idle();

      // Round-robin interleave table (expectations for the RR instance)
      for (int j = 1; j <= 4; j++)
         for (int i = 1; i <= 3; i++) begin
            v = '{1, tree_id_t'(i), word_t'(4096*i + j), 0, 4'hF, 0, 0, 0};
            tbl.push_back(v);
         end
      for (int n = 0; n < 12; n++) begin
         v = '{0, 0, 0, 1, 4'hF, 1, tree_id_t'(n % 3 + 1), word_t'(4096*(n % 3 + 1) + n / 3 + 1)};
         tbl.push_back(v);
      end
      foreach (tbl[i]) begin
         step(tbl[i].push, tbl[i].id, tbl[i].data, tbl[i].pop, tbl[i].en);
         check($sformatf("tbl%0d_valid", i), 32'(pop_valid[0]), 32'(tbl[i].exp_valid));
         if (tbl[i].exp_valid) begin
            check($sformatf("tbl%0d_id", i),   32'(pop_id[0]),   32'(tbl[i].exp_id));
            check($sformatf("tbl%0d_data", i), 32'(pop_data[0]), 32'(tbl[i].exp_data));
         end
      end
      check("tbl_empty_after", 32'(empty[0]), 32'hF);

      // Fill tree 2, overflow, drain across pointer wrap
      for (int n = 0; n < 16; n++) step(1, 2, word_t'(n), 0, 4'hF);
      check("fill_full2", 32'(full[0][2]), 32'd1);
      step(1, 2, 16'hDEAD, 0, 4'hF);
      check("ovf_drop", 32'(drop[0]), 32'd1);
      idle();
      check("ovf_drop_clear", 32'(drop[0]), 32'd0);
      for (int n = 0; n < 16; n++) begin
         step(0, 0, 0, 1, 4'hF);
         expect_pop(0, $sformatf("wrap%0d", n), 2, word_t'(n));
      end
      check("wrap_empty2", 32'(empty[0][2]), 32'd1);

      // Enable mask
      step(1, 0, 16'hA000, 0, 4'hF);
      step(1, 0, 16'hA001, 0, 4'hF);
      step(1, 3, 16'hB000, 0, 4'hF);
      step(1, 3, 16'hB001, 0, 4'hF);
      step(0, 0, 0, 1, 4'b0111); expect_pop(0, "mask0", 0, 16'hA000);
      step(0, 0, 0, 1, 4'b0111); expect_pop(0, "mask1", 0, 16'hA001);
      step(0, 0, 0, 1, 4'b0111);
      check("mask_uf", 32'(uf[0]), 32'd1);
      check("mask_uf_valid", 32'(pop_valid[0]), 32'd0);
      check("mask_hold_data", 32'(pop_data[0]), 32'hA001);
      step(0, 0, 0, 1, 4'hF); expect_pop(0, "mask3", 3, 16'hB000);
      step(0, 0, 0, 1, 4'hF); expect_pop(0, "mask4", 3, 16'hB001);
      idle();
      check("nopop_valid", 32'(pop_valid[0]), 32'd0);

      // Strict priority with a late push to tree 0
      step(1, 1, 16'hC100, 0, 4'hF);
      step(1, 1, 16'hC101, 0, 4'hF);
      step(1, 1, 16'hC102, 0, 4'hF);
      step(1, 2, 16'hC200, 0, 4'hF);
      step(1, 2, 16'hC201, 0, 4'hF);
      step(0, 0, 0,        1, 4'hF); expect_pop(1, "sp0", 1, 16'hC100);
      step(1, 0, 16'hC000, 1, 4'hF); expect_pop(1, "sp1", 1, 16'hC101);
      step(0, 0, 0,        1, 4'hF); expect_pop(1, "sp2", 0, 16'hC000);
      step(0, 0, 0,        1, 4'hF); expect_pop(1, "sp3", 1, 16'hC102);
      step(0, 0, 0,        1, 4'hF); expect_pop(1, "sp4", 2, 16'hC200);
      step(0, 0, 0,        1, 4'hF); expect_pop(1, "sp5", 2, 16'hC201);

      // Pop on all-empty
      step(0, 0, 0, 1, 4'hF);
      step(0, 0, 0, 1, 4'hF);
      for (int m = 0; m < 2; m++) begin
         check("empty_uf",    32'(uf[m]), 32'd1);
         check("empty_valid", 32'(pop_valid[m]), 32'd0);
      end
      idle();
      check("uf_clear", 32'(uf[0]), 32'd0);

      // Randomised traffic against the model
      for (int n = 0; n < 3000; n++) begin
         step($urandom_range(0, 99) < 60, tree_id_t'($urandom_range(0, 3)),
              word_t'($urandom), $urandom_range(0, 99) < 50,
              ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF);
      end

      // Asynchronous reset mid-stream
      for (int n = 0; n < 20; n++) step(1, tree_id_t'(n % 4), word_t'(16'h5000 + n), 0, 4'hF);
      step(1, 1, 16'h5555, 1, 4'hF);
      #2 rst_n = 1'b0;
      #1;
      for (int m = 0; m < 2; m++) begin
         check("arst_empty", 32'(empty[m]), 32'hF);
         check("arst_full",  32'(full[m]),  32'h0);
         check("arst_valid", 32'(pop_valid[m]), 32'h0);
         check("arst_id",    32'(pop_id[m]),    32'h0);
         check("arst_data",  32'(pop_data[m]),  32'h0);
         check("arst_drop",  32'(drop[m]), 32'h0);
         check("arst_uf",    32'(uf[m]), 32'h0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      idle();
      step(0, 0, 0, 1, 4'hF);
      check("post_rst_uf", 32'(uf[0]), 32'd1);
      idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
